icache_ctrl_nway: RTL and testbench
===================================

// Module: icache_ctrl_nway
// PURPOSE
//  Parametrised N-way I-cache control FSM with multi-beat line refill, round-robin victim selection and whole-cache invalidate.
//  Sits between IF-stage request handshake, tag/data RAM arrays (way-indexed write enables) and AXI-side read-burst bridge.
//  Supersedes fixed 2-way single-beat controller.
// PARAMETERS
//  ADDR_W      32   request/memory address width
//  WAYS        2    associativity, power of 2, >=2
//  LINE_WORDS  4    32-bit words per line, power of 2, >=1
//  SETS        256  sets per way; sets flush walk length
// PORTS
//  clk              in   1            clock
//  rst              in   1            reset, synchronous, active-high
//  req_valid        in   1            IF fetch request
//  req_addr         in   ADDR_W       fetch byte address
//  req_ready        out  1            request accepted this cycle
//  rbuf_we          out  1            latch req_addr into request buffer
//  hit              in   WAYS         per-way tag match, valid in LOOKUP
//  resp_valid       out  1            fetch data valid, 1-cycle pulse
//  resp_way         out  log2(WAYS)   way supplying hit data
//  resp_from_mem    out  1            resp data from refill capture reg
//  mem_rd_req       out  1            line read request
//  mem_rd_addr      out  ADDR_W       line-aligned address, offset bits 0
//  mem_rd_ready     in   1            bridge accepts read request
//  mem_ret_valid    in   1            one return beat valid
//  ret_we           out  1            capture beat as fetch result (critical word)
//  refill_we        out  WAYS         one-hot array write, victim way
//  refill_word      out  log2(LINE_WORDS)  word index of current beat
//  flush_req        in   1            invalidate all lines
//  flush_we         out  1            clear valid bits of set flush_set, all ways
//  flush_set        out  log2(SETS)   set under invalidation
//  flush_done       out  1            1-cycle pulse, flush complete
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; beat counter 0; victim pointer 0; flush_set 0.
//  States IDLE, LOOKUP, MISS, REFILL, RESP, FLUSH; registered state, Moore/Mealy outputs below.
//  IDLE: flush_req -> FLUSH, priority over req_valid, req_ready=0.
//   Otherwise req_ready=1; req_valid -> rbuf_we=1, latch addr, -> LOOKUP.
//  LOOKUP: |hit -> resp_valid=1, resp_way=lowest set index in hit (multi-hit tolerated), -> IDLE. Hit latency 2 cycles from accept.
//   ~|hit -> latch line addr and victim=ptr, -> MISS.
//  MISS: mem_rd_req=1 held, mem_rd_addr stable until mem_rd_ready=1; then beat cnt=0, -> REFILL.
//  REFILL: per mem_ret_valid: refill_we[victim]=1, refill_word=cnt, cnt++.
//   ret_we=1 on beat whose cnt equals latched req word offset.
//   Beat with cnt==LINE_WORDS-1 -> RESP; no early exit; stalls indefinitely without beats.
//  RESP: resp_valid=1, resp_from_mem=1, resp_way=victim; ptr=(ptr+1) mod WAYS; -> IDLE.
//  FLUSH: flush_we=1 each cycle, flush_set 0..SETS-1; at SETS-1 flush_done=1, flush_set=0, -> IDLE. Exactly SETS cycles; req_valid ignored.
//  flush_req while not IDLE: not dropped, serviced on next IDLE visit (level-sensitive input).
//  mem_ret_valid outside REFILL ignored. No second miss outstanding.
//  rst mid-REFILL: back to IDLE immediately; bridge must also be reset; stray beats ignored.
//  Counter widths exact log2; wrap modulo width; ptr advances only on refill.
// STRUCTURE
//  icache_pkg: state enum, WAY_W/OFS_W/SET_W localparams ($clog2), line-align function.
//  Sub-module icache_victim_sel: round-robin pointer, advance input, victim output.
//  Everything else in one always_ff state/counter block plus one always_comb output block.
// TESTING
//  Reset, req 0x1000, hit=2'b10 in LOOKUP -> resp_valid on cycle 2, resp_way=1, no mem_rd_req.
//  Miss 0x1008 (LINE_WORDS=4), ready after 3 cycles -> mem_rd_addr=0x1000, 4 refill_we[0] pulses, word 0..3, ret_we on word 2, RESP, ptr=1.
//  Second miss -> refill_we[1], third -> refill_we[0] (round robin wraps at WAYS=2).
//  flush_req and req_valid same IDLE cycle -> req_ready=0, SETS flush_we cycles, flush_done once, then request accepted.
//  rst asserted during beat 2 of refill -> next cycle IDLE, all outputs 0, later mem_ret_valid ignored.
//  hit=2'b11 -> resp_way=0; gaps between mem_ret_valid beats -> cnt holds, exactly LINE_WORDS writes.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the N-way I-cache controller: FSM state encoding,
// index-width helper and line-alignment mask.
package icache_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOOKUP = 3'd1;
    localparam state_t ST_MISS   = 3'd2;
    localparam state_t ST_REFILL = 3'd3;
    localparam state_t ST_RESP   = 3'd4;
    localparam state_t ST_FLUSH  = 3'd5;

    // Index width for n items; a single item still needs a 1-bit port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Mask that clears the byte offset within a line of 32-bit words.
    function automatic logic [63:0] line_align_mask(input int unsigned line_words);
        return ~(64'(line_words) * 64'd4 - 64'd1);
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Round-robin victim pointer: names the way to replace on the next miss and
// steps to the following way each time a refill completes.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     advance,
    output logic [idx_w(WAYS)-1:0]   victim
);

    localparam int                WAY_W    = idx_w(WAYS);
    localparam logic [WAY_W-1:0]  LAST_WAY = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] ptr_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (ptr_q == LAST_WAY) ? '0 : ptr_q + 1'b1;
        end
    end

    assign victim = ptr_q;

endmodule

// File: rtl/icache_ctrl_nway.sv
// N-way I-cache control FSM: hit lookup, multi-beat line refill into a
// round-robin victim way, and a set-by-set whole-cache invalidate walk.
module icache_ctrl_nway
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           req_ready,
    output logic                           rbuf_we,
    input  logic [WAYS-1:0]                hit,
    output logic                           resp_valid,
    output logic [idx_w(WAYS)-1:0]         resp_way,
    output logic                           resp_from_mem,
    output logic                           mem_rd_req,
    output logic [ADDR_W-1:0]              mem_rd_addr,
    input  logic                           mem_rd_ready,
    input  logic                           mem_ret_valid,
    output logic                           ret_we,
    output logic [WAYS-1:0]                refill_we,
    output logic [idx_w(LINE_WORDS)-1:0]   refill_word,
    input  logic                           flush_req,
    output logic                           flush_we,
    output logic [idx_w(SETS)-1:0]         flush_set,
    output logic                           flush_done
);

    localparam int                 WAY_W     = idx_w(WAYS);
    localparam int                 OFS_W     = idx_w(LINE_WORDS);
    localparam int                 SET_W     = idx_w(SETS);
    localparam logic [ADDR_W-1:0]  LINE_MASK = ADDR_W'(line_align_mask(LINE_WORDS));
    localparam logic [OFS_W-1:0]   LAST_BEAT = OFS_W'(LINE_WORDS - 1);
    localparam logic [SET_W-1:0]   LAST_SET  = SET_W'(SETS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] line_addr_q;
    logic [WAY_W-1:0]  victim_q;
    logic [WAY_W-1:0]  ptr;
    logic [OFS_W-1:0]  cnt_q;
    logic [OFS_W-1:0]  word_ofs;
    logic [SET_W-1:0]  flush_set_q;
    logic              advance;

    // Word offset of the request inside its line; a one-word line has none.
    assign word_ofs = (LINE_WORDS > 1) ? addr_q[2 +: OFS_W] : '0;
    assign advance  = (state_q == ST_RESP);

    icache_victim_sel #(
        .WAYS (WAYS)
    ) u_victim_sel (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .victim  (ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            line_addr_q <= '0;
            victim_q    <= '0;
            cnt_q       <= '0;
            flush_set_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q <= ST_FLUSH;
                    end else if (req_valid) begin
                        addr_q  <= req_addr;
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (|hit) begin
                        state_q <= ST_IDLE;
                    end else begin
                        line_addr_q <= addr_q & LINE_MASK;
                        victim_q    <= ptr;
                        state_q     <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (mem_rd_ready) begin
                        cnt_q   <= '0;
                        state_q <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    // Only real beats advance; the line always completes in full.
                    if (mem_ret_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (flush_set_q == LAST_SET) begin
                        flush_set_q <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        flush_set_q <= flush_set_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path through
        // the block can leave one unassigned and infer a latch.
        req_ready     = 1'b0;
        rbuf_we       = 1'b0;
        resp_valid    = 1'b0;
        resp_way      = '0;
        resp_from_mem = 1'b0;
        mem_rd_req    = 1'b0;
        mem_rd_addr   = '0;
        ret_we        = 1'b0;
        refill_we     = '0;
        refill_word   = '0;
        flush_we      = 1'b0;
        flush_set     = '0;
        flush_done    = 1'b0;

        // Outputs stay low while reset is held, even before the state register clears.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    req_ready = !flush_req;
                    rbuf_we   = !flush_req && req_valid;
                end
                ST_LOOKUP: begin
                    if (|hit) begin
                        resp_valid = 1'b1;
                        for (int i = WAYS - 1; i >= 0; i--) begin
                            if (hit[i]) begin
                                resp_way = WAY_W'(i);
                            end
                        end
                    end
                end
                ST_MISS: begin
                    mem_rd_req  = 1'b1;
                    mem_rd_addr = line_addr_q;
                end
                ST_REFILL: begin
                    if (mem_ret_valid) begin
                        refill_we[victim_q] = 1'b1;
                        refill_word         = cnt_q;
                        ret_we              = (cnt_q == word_ofs);
                    end
                end
                ST_RESP: begin
                    resp_valid    = 1'b1;
                    resp_from_mem = 1'b1;
                    resp_way      = victim_q;
                end
                ST_FLUSH: begin
                    flush_we   = 1'b1;
                    flush_set  = flush_set_q;
                    flush_done = (flush_set_q == LAST_SET);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Directed bench for icache_ctrl_nway: table of hit/miss accesses plus
// hand-written flush and reset-during-refill sequences.
module tb_icache_ctrl_nway;

    localparam int ADDR_W     = 32;
    localparam int WAYS       = 2;
    localparam int LINE_WORDS = 4;
    localparam int SETS       = 256;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rbuf_we;
    logic [WAYS-1:0]   hit;
    logic              resp_valid;
    logic [0:0]        resp_way;
    logic              resp_from_mem;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ready;
    logic              mem_ret_valid;
    logic              ret_we;
    logic [WAYS-1:0]   refill_we;
    logic [1:0]        refill_word;
    logic              flush_req;
    logic              flush_we;
    logic [7:0]        flush_set;
    logic              flush_done;

    icache_ctrl_nway #(
        .ADDR_W     (ADDR_W),
        .WAYS       (WAYS),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rbuf_we       (rbuf_we),
        .hit           (hit),
        .resp_valid    (resp_valid),
        .resp_way      (resp_way),
        .resp_from_mem (resp_from_mem),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_ready  (mem_rd_ready),
        .mem_ret_valid (mem_ret_valid),
        .ret_we        (ret_we),
        .refill_we     (refill_we),
        .refill_word   (refill_word),
        .flush_req     (flush_req),
        .flush_we      (flush_we),
        .flush_set     (flush_set),
        .flush_done    (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every output except req_ready, packed for all-zero checks.
    logic [63:0] other_outs;
    assign other_outs = {12'd0, rbuf_we, resp_valid, resp_way, resp_from_mem, mem_rd_req,
                         mem_rd_addr, ret_we, refill_we, refill_word, flush_we, flush_set,
                         flush_done};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // hit == 0 marks a miss; exp_way is the hit way or the refill victim.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  hit;
        int          rdy_delay;
        bit          gaps;
        logic [0:0]  exp_way;
        logic [31:0] exp_line;
        int          exp_word;
    } vec_t;

    vec_t vecs[6];

    task automatic do_access(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = v.addr;
        #1;
        check("accept.req_ready", req_ready, 1);
        check("accept.rbuf_we", rbuf_we, 1);
        @(negedge clk);
        req_valid = 1'b0;
        hit       = v.hit;
        #1;
        if (v.hit != 2'b00) begin
            check("hit.resp_valid", resp_valid, 1);
            check("hit.resp_way", resp_way, v.exp_way);
            check("hit.resp_from_mem", resp_from_mem, 0);
            check("hit.mem_rd_req", mem_rd_req, 0);
            @(negedge clk);
            hit = '0;
            #1;
            check("hit.pulse_end", resp_valid, 0);
            check("hit.idle_ready", req_ready, 1);
        end else begin
            check("miss.resp_valid", resp_valid, 0);
            @(negedge clk);
            hit = '0;
            for (int c = 0; c < v.rdy_delay; c++) begin
                #1;
                check("miss.rd_req_held", mem_rd_req, 1);
                check("miss.rd_addr_wait", mem_rd_addr, v.exp_line);
                @(negedge clk);
            end
            mem_rd_ready = 1'b1;
            #1;
            check("miss.rd_req", mem_rd_req, 1);
            check("miss.rd_addr", mem_rd_addr, v.exp_line);
            @(negedge clk);
            mem_rd_ready = 1'b0;
            for (int b = 0; b < LINE_WORDS; b++) begin
                if (v.gaps) begin
                    #1;
                    check("refill.gap_we", refill_we, 0);
                    check("refill.gap_ret_we", ret_we, 0);
                    @(negedge clk);
                end
                mem_ret_valid = 1'b1;
                #1;
                check("refill.we", refill_we, 64'(2'b01 << v.exp_way));
                check("refill.word", refill_word, b);
                check("refill.ret_we", ret_we, (b == v.exp_word));
                check("refill.no_resp", resp_valid, 0);
                @(negedge clk);
                mem_ret_valid = 1'b0;
            end
            #1;
            check("resp.valid", resp_valid, 1);
            check("resp.from_mem", resp_from_mem, 1);
            check("resp.way", resp_way, v.exp_way);
            check("resp.no_write", refill_we, 0);
            @(negedge clk);
            #1;
            check("resp.pulse_end", resp_valid, 0);
            check("resp.idle_ready", req_ready, 1);
        end
    endtask

    initial begin
        vec_t fin;
        int   nwe;
        int   ndone;
        bit   back;

        vecs[0] = '{32'h0000_1000, 2'b10, 0, 1'b0, 1'b1, 32'h0,         0};
        vecs[1] = '{32'h0000_1008, 2'b00, 3, 1'b0, 1'b0, 32'h0000_1000, 2};
        vecs[2] = '{32'h0000_2004, 2'b11, 0, 1'b0, 1'b0, 32'h0,         0};
        vecs[3] = '{32'h0000_200C, 2'b00, 0, 1'b1, 1'b1, 32'h0000_2000, 3};
        vecs[4] = '{32'h0000_3000, 2'b00, 1, 1'b0, 1'b0, 32'h0000_3000, 0};
        vecs[5] = '{32'h0000_0044, 2'b01, 0, 1'b0, 1'b0, 32'h0,         0};

        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        hit           = '0;
        mem_rd_ready  = 1'b0;
        mem_ret_valid = 1'b0;
        flush_req     = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst.req_ready_held", req_ready, 0);
        check("rst.outputs_held", other_outs, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.req_ready", req_ready, 1);
        check("rst.outputs", other_outs, 0);

        for (int i = 0; i < 6; i++) begin
            do_access(vecs[i]);
        end

        // Flush wins over a simultaneous request; the request waits and is taken after.
        @(negedge clk);
        flush_req = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_7000;
        #1;
        check("flush.req_ready", req_ready, 0);
        check("flush.rbuf_we", rbuf_we, 0);
        @(negedge clk);
        flush_req = 1'b0;
        nwe   = 0;
        ndone = 0;
        back  = 1'b0;
        for (int c = 0; c < SETS + 20; c++) begin
            #1;
            if (req_ready) begin
                back = 1'b1;
                break;
            end
            if (flush_we) begin
                check("flush.set", flush_set, nwe);
                check("flush.done_at_last", flush_done, (nwe == SETS - 1));
                if (flush_done) ndone++;
                nwe++;
            end
            @(negedge clk);
        end
        check("flush.returned", back, 1);
        check("flush.we_cycles", nwe, SETS);
        check("flush.done_count", ndone, 1);
        check("flush.then_accept", rbuf_we, 1);
        @(negedge clk);
        req_valid = 1'b0;
        hit       = 2'b01;
        #1;
        check("flush.post_hit", resp_valid, 1);
        check("flush.post_way", resp_way, 0);
        @(negedge clk);
        hit = '0;

        // Reset lands on the third refill beat; pointer is at way 1 here.
        req_valid = 1'b1;
        req_addr  = 32'h0000_5000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_rd_ready = 1'b1;
        #1;
        check("rstmid.rd_addr", mem_rd_addr, 32'h0000_5000);
        @(negedge clk);
        mem_rd_ready  = 1'b0;
        mem_ret_valid = 1'b1;
        #1;
        check("rstmid.victim", refill_we, 2'b10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid.outputs_held", other_outs, 0);
        check("rstmid.req_ready_held", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid.idle_ready", req_ready, 1);
        check("rstmid.outputs", other_outs, 0);
        @(negedge clk);
        #1;
        check("rstmid.stray_beat", refill_we, 0);
        @(negedge clk);
        mem_ret_valid = 1'b0;

        // Pointer was reset, so the next miss fills way 0 again.
        fin = '{32'h0000_6004, 2'b00, 2, 1'b0, 1'b0, 32'h0000_6000, 1};
        do_access(fin);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
